// File: rtl/prio_sel_arbiter.sv
// prio_sel_arbiter: sequential arbiter for a 6-input priority-select datapath.
// Grants one requester at a time on a shared output lane, holds the grant
// across multi-cycle transfers while lock is high, forces a release after
// HOLD_MAX consecutive cycles (with a one-cycle cool-down that masks the
// released owner), and honours a late veto on requester 3. The selected data
// is registered so the late veto never reaches the output combinationally.
//
// Optional feature: define PRIO_SEL_ARBITER_RR_EN for round-robin winner
// selection; otherwise index 0 has the highest fixed priority.
module prio_sel_arbiter #(
    parameter int NREQ     = 6,
    parameter int DW       = 1,
    parameter int HOLD_MAX = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    lock,
    input  logic               late_veto,
    input  logic [NREQ*DW-1:0] data,
    output logic [NREQ-1:0]    gnt,
    output logic               gnt_vld,
    output logic [2:0]         gnt_id,
    output logic [DW-1:0]      z
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        COOL  = 2'd2
    } state_t;

    localparam int VETO_IDX = 3;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              gnt_vld_q, gnt_vld_d;
    logic [2:0]        gnt_id_q, gnt_id_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [NREQ-1:0]   mask_q, mask_d;
    logic [DW-1:0]     z_q, z_d;

    logic [2:0]        arb_ptr;
    logic [NREQ-1:0]   elig;
    logic [NREQ-1:0]   elig_ex;
    logic              any_all, any_ex;
    logic [2:0]        win_all, win_ex;
    logic              do_grant;
    logic [2:0]        grant_idx;
    logic              owner_drop;

`ifdef PRIO_SEL_ARBITER_RR_EN
    logic [2:0]        rr_ptr_q, rr_ptr_d;
    assign arb_ptr = rr_ptr_q;
`else
    assign arb_ptr = 3'd0;
`endif

    // First set bit of v at or after ptr, wrapping modulo NREQ.
    function automatic logic [2:0] pick_idx(input logic [NREQ-1:0] v,
                                            input logic [2:0]      ptr);
        logic [2:0] win;
        logic       found;
        int         idx;
        win   = 3'd0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && v[idx]) begin
                win   = 3'(idx);
                found = 1'b1;
            end
        end
        return win;
    endfunction

    // Eligibility and the two arbitration views: everyone, and everyone but the owner.
    always_comb begin
        elig = req & ~mask_q;
        if (late_veto) elig[VETO_IDX] = 1'b0;
        elig_ex = elig & ~gnt_q;
        any_all = |elig;
        any_ex  = |elig_ex;
        win_all = pick_idx(elig, arb_ptr);
        win_ex  = pick_idx(elig_ex, arb_ptr);
    end

    // Next-state, grant, hold-count, mask and data-capture decisions.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        cnt_d     = cnt_q;
        mask_d    = mask_q;
        z_d       = z_q;
        do_grant  = 1'b0;
        grant_idx = 3'd0;
        owner_drop = !req[gnt_id_q] ||
                     ((gnt_id_q == 3'(VETO_IDX)) && late_veto);
`ifdef PRIO_SEL_ARBITER_RR_EN
        rr_ptr_d  = rr_ptr_q;
`endif

        case (state_q)
            IDLE: begin
                if (any_all) begin
                    do_grant  = 1'b1;
                    grant_idx = win_all;
                end
            end
            GRANT: begin
                z_d = data[int'(gnt_id_q)*DW +: DW];
                if (owner_drop) begin
                    if (any_ex) begin
                        do_grant  = 1'b1;
                        grant_idx = win_ex;
                    end else begin
                        state_d  = IDLE;
                        gnt_d    = '0;
                        gnt_id_d = 3'd0;
                        cnt_d    = 4'd0;
                    end
                end else if (!lock[gnt_id_q]) begin
                    if (any_all) begin
                        do_grant  = 1'b1;
                        grant_idx = win_all;
                    end else begin
                        state_d  = IDLE;
                        gnt_d    = '0;
                        gnt_id_d = 3'd0;
                        cnt_d    = 4'd0;
                    end
                end else if (cnt_q >= 4'(HOLD_MAX)) begin
                    mask_d[gnt_id_q] = 1'b1;
                    state_d  = COOL;
                    gnt_d    = '0;
                    gnt_id_d = 3'd0;
                    cnt_d    = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            COOL: begin
                mask_d = '0;
                if (any_all) begin
                    do_grant  = 1'b1;
                    grant_idx = win_all;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d  = IDLE;
                gnt_d    = '0;
                gnt_id_d = 3'd0;
                cnt_d    = 4'd0;
                mask_d   = '0;
            end
        endcase

        if (do_grant) begin
            state_d  = GRANT;
            gnt_d    = {{(NREQ-1){1'b0}}, 1'b1} << grant_idx;
            gnt_id_d = grant_idx;
            cnt_d    = 4'd1;
`ifdef PRIO_SEL_ARBITER_RR_EN
            rr_ptr_d = (grant_idx == 3'(NREQ-1)) ? 3'd0 : grant_idx + 3'd1;
`endif
        end

        gnt_vld_d = |gnt_d;
    end

    // State and output registers; reset drops any grant immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_vld_q <= 1'b0;
            gnt_id_q  <= 3'd0;
            cnt_q     <= 4'd0;
            mask_q    <= '0;
            z_q       <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_vld_q <= gnt_vld_d;
            gnt_id_q  <= gnt_id_d;
            cnt_q     <= cnt_d;
            mask_q    <= mask_d;
            z_q       <= z_d;
        end
    end

`ifdef PRIO_SEL_ARBITER_RR_EN
    // Round-robin pointer: names the highest-priority index for the next arbitration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= 3'd0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    assign gnt     = gnt_q;
    assign gnt_vld = gnt_vld_q;
    assign gnt_id  = gnt_id_q;
    assign z       = z_q;

endmodule

// File: tb/tb_prio_sel_arbiter.sv
// tb_prio_sel_arbiter: directed self-checking bench for prio_sel_arbiter.
// Covers reset (including mid-grant), fixed priority with back-to-back
// handover, the hold limit and cool-down, the late veto, the data path and
// (when PRIO_SEL_ARBITER_RR_EN is defined) round-robin rotation.
module tb_prio_sel_arbiter;

    localparam int NREQ = 6;
    localparam int DW   = 1;

    logic               clk;
    logic               rst_n;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    lock;
    logic               late_veto;
    logic [NREQ*DW-1:0] data;
    logic [NREQ-1:0]    gnt;
    logic               gnt_vld;
    logic [2:0]         gnt_id;
    logic [DW-1:0]      z;

    int compared;
    int mismatched;

    prio_sel_arbiter #(.NREQ(NREQ), .DW(DW), .HOLD_MAX(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .lock      (lock),
        .late_veto (late_veto),
        .data      (data),
        .gnt       (gnt),
        .gnt_vld   (gnt_vld),
        .gnt_id    (gnt_id),
        .z         (z)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: count it, and report tag/observed/expected on a miss.
    task automatic check_output(input string tag, input logic [31:0] obs,
                                input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Grant, valid and id checked together; valid is implied by the grant.
    task automatic check_grant(input string tag, input logic [NREQ-1:0] exp_gnt,
                               input logic [2:0] exp_id);
        check_output({tag, ".gnt"}, 32'(gnt), 32'(exp_gnt));
        check_output({tag, ".vld"}, 32'(gnt_vld), 32'(exp_gnt != '0));
        check_output({tag, ".id"}, 32'(gnt_id), 32'(exp_id));
    endtask

    // Advance one clock edge and settle just after it.
    task automatic apply_stimulus;
        @(posedge clk);
        #1;
    endtask

    // Clean reset with all inputs idle.
    task automatic do_reset;
        req       = '0;
        lock      = '0;
        late_veto = 1'b0;
        data      = '0;
        rst_n     = 1'b0;
        apply_stimulus();
        rst_n = 1'b1;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        req        = '0;
        lock       = '0;
        late_veto  = 1'b0;
        data       = '0;
        #12;
        check_grant("reset", 6'b000000, 3'd0);
        check_output("reset.z", 32'(z), 32'd0);

        // Reset mid-grant.
        $display("[TB] reset mid-grant");
        req   = 6'b000100;
        lock  = 6'b111111;
        data  = 6'b000100;
        rst_n = 1'b1;
        apply_stimulus();
        check_grant("rmg.first", 6'b000100, 3'd2);
        apply_stimulus();
        check_output("rmg.z1", 32'(z), 32'd1);
        rst_n = 1'b0;
        #1;
        check_grant("rmg.async", 6'b000000, 3'd0);
        check_output("rmg.async.z", 32'(z), 32'd0);
        apply_stimulus();
        rst_n = 1'b1;
        apply_stimulus();
        check_grant("rmg.regrant", 6'b000100, 3'd2);

        // Fixed priority with back-to-back handover.
        $display("[TB] fixed priority");
        do_reset();
        req  = 6'b100110;
        lock = 6'b000000;
        apply_stimulus();
        check_grant("fp.c1", 6'b000010, 3'd1);
        apply_stimulus();
        check_grant("fp.c2", 6'b000010, 3'd1);
        req = 6'b100100;
        apply_stimulus();
        check_grant("fp.b2b", 6'b000100, 3'd2);
        apply_stimulus();
        check_grant("fp.keep2", 6'b000100, 3'd2);
        req = 6'b100000;
        apply_stimulus();
        check_grant("fp.to5", 6'b100000, 3'd5);

        // Hold limit, cool-down, and re-grant paths.
        $display("[TB] hold limit");
        do_reset();
        req  = 6'b010000;
        lock = 6'b010000;
        for (int i = 1; i <= 4; i++) begin
            apply_stimulus();
            check_grant($sformatf("hold.c%0d", i), 6'b010000, 3'd4);
        end
        apply_stimulus();
        check_grant("hold.cool", 6'b000000, 3'd0);
        apply_stimulus();
        check_grant("hold.idle", 6'b000000, 3'd0);
        apply_stimulus();
        check_grant("hold.regrant4", 6'b010000, 3'd4);
        req = 6'b110000;
        apply_stimulus();
        apply_stimulus();
        apply_stimulus();
        check_grant("hold.c4b", 6'b010000, 3'd4);
        apply_stimulus();
        check_grant("hold.cool2", 6'b000000, 3'd0);
        apply_stimulus();
        check_grant("hold.to5", 6'b100000, 3'd5);

        // Late veto on requester 3.
        $display("[TB] late veto");
        do_reset();
        req       = 6'b001000;
        late_veto = 1'b1;
        apply_stimulus();
        check_grant("veto.blk1", 6'b000000, 3'd0);
        apply_stimulus();
        check_grant("veto.blk2", 6'b000000, 3'd0);
        late_veto = 1'b0;
        apply_stimulus();
        check_grant("veto.grant", 6'b001000, 3'd3);
        lock      = 6'b001000;
        late_veto = 1'b1;
        apply_stimulus();
        check_grant("veto.drop", 6'b000000, 3'd0);

        // Data path: slice 2 registered one cycle behind, held after release.
        $display("[TB] data path");
        do_reset();
        req  = 6'b000100;
        lock = 6'b000100;
        data = 6'b111011;
        apply_stimulus();
        check_output("dp.z0", 32'(z), 32'd0);
        data = 6'b000100;
        apply_stimulus();
        check_output("dp.z1", 32'(z), 32'd1);
        data = 6'b111011;
        apply_stimulus();
        check_output("dp.z2", 32'(z), 32'd0);
        data = 6'b000100;
        apply_stimulus();
        check_output("dp.z3", 32'(z), 32'd1);
        req = 6'b000000;
        apply_stimulus();
        check_grant("dp.rel", 6'b000000, 3'd0);
        check_output("dp.z4", 32'(z), 32'd1);
        data = 6'b111011;
        apply_stimulus();
        check_output("dp.hold", 32'(z), 32'd1);

`ifdef PRIO_SEL_ARBITER_RR_EN
        // Round-robin rotation across all requesters.
        $display("[TB] round robin");
        do_reset();
        req  = 6'b111111;
        lock = 6'b000000;
        for (int i = 0; i < 7; i++) begin
            apply_stimulus();
            check_grant($sformatf("rr.c%0d", i), 6'(1 << (i % 6)), 3'(i % 6));
        end
`else
        // Fixed priority keeps requester 0 when everyone requests.
        $display("[TB] all requesting, fixed priority");
        do_reset();
        req  = 6'b111111;
        lock = 6'b000000;
        for (int i = 0; i < 3; i++) begin
            apply_stimulus();
            check_grant($sformatf("all.c%0d", i), 6'b000001, 3'd0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/prio_sel_arbiter.md
Name: prio_sel_arbiter

Overview:
- Sequential arbiter and controller for a 6-input priority-select datapath.
- Arbitrates requesters that share a single output bit lane and holds the grant across multi-cycle transfers.
- Enforces a maximum hold time and honours a late-arriving veto on requester 3.
- Registers the selected data so the late veto never sits on the combinational output path.

Parameters:
- NREQ, 6, number of requesters (index 0 is highest priority in fixed mode).
- DW, 1, data width per requester.
- HOLD_MAX, 4, maximum consecutive grant cycles before forced release (legal range 1..15).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NREQ  request vector, level-sensitive.
- lock  input  NREQ  per-requester "keep grant" qualifier.
- late_veto  input  1  late-arriving disable of requester 3.
- data  input  NREQ*DW  requester data; slice i = data[i*DW +: DW].
- gnt  output  NREQ  registered one-hot grant; all-zero when no owner.
- gnt_vld  output  1  registered; high when gnt is non-zero.
- gnt_id  output  3  registered binary index of owner; 0 when no owner.
- z  output  DW  registered data of current owner; holds last value when no owner.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, gnt=0, gnt_vld=0, gnt_id=0, z=0, hold count=0, mask=0. Reset mid-grant drops the grant immediately, with no completion of the transfer.
- Eligibility: elig[i] = req[i] & ~mask[i] & ~(i==3 & late_veto).
- Winner: lowest eligible index.
- State IDLE:
  - If any elig: next cycle gnt=onehot(winner), gnt_vld=1, gnt_id=winner, cnt=1, state=GRANT.
  - Otherwise remain in IDLE.
  - Latency is one cycle from req to gnt.
- State GRANT (owner o). The following are evaluated each cycle, in this precedence:
  - (a) If !req[o], or (o==3 & late_veto): normal release. If a winner exists among elig excluding o, grant it back-to-back next cycle with cnt=1. Otherwise IDLE with gnt=0.
  - (b) Else if !lock[o]: single-beat release. Re-arbitrate as in (a), but o stays eligible, so a higher-priority requester wins if present; if o is the only one, it is re-granted with cnt=1.
  - (c) Else if cnt==HOLD_MAX: forced release. Set mask[o]=1, state=COOL, gnt=0.
  - (d) Else keep o and increment cnt.
- State COOL:
  - Exactly one cycle with gnt=0 and gnt_vld=0.
  - Arbitration runs with mask applied. A winner is granted next cycle (state GRANT); otherwise go to IDLE.
  - mask clears at the end of the COOL cycle whatever the outcome.
- z: each cycle while state=GRANT, z <= data slice of gnt_id, so z is data registered one cycle after the grant cycle. While not in GRANT, z holds.
- gnt is always one-hot or zero; there is never more than one bit set.
- cnt is 4 bits and saturates at HOLD_MAX; there is no wrap.
- A request dropped and re-raised in the same cycle as the release is treated as present. Arbitration sees only the sampled level.

Optional Feature:
- Macro: PRIO_SEL_ARBITER_RR_EN.
- Defined:
  - Round-robin winner selection. An rr_ptr (reset 0) names the highest-priority index.
  - The winner is the first elig index at or after rr_ptr, modulo NREQ.
  - On every new grant, rr_ptr <= winner+1 mod NREQ (5 wraps to 0).
  - mask and HOLD_MAX behaviour are unchanged.
- Undefined: fixed priority, index 0 highest; no rr_ptr register exists.

Test Plan:
- Reset mid-grant: req=6'b000100, lock=all-1, assert rst_n=0 while granted -> gnt=0, gnt_vld=0, z=0 in the same cycle (asynchronous); after release, first grant to 2 one cycle after the first clk edge.
- Fixed priority with back-to-back: req=6'b100110, lock=0 -> gnt sequence 000010 held while req[1]=1; drop req[1] -> next cycle gnt=000100 with no idle gap.
- Hold limit: req[4]=1, lock[4]=1, HOLD_MAX=4 -> gnt=010000 for exactly 4 cycles, then one COOL cycle with gnt=0; with req[5]=1 also present, gnt=100000 after COOL; if only req[4]=1, 4 is re-granted after COOL.
- Late veto: req=6'b001000, late_veto=1 -> no grant, gnt_vld=0; late_veto 1->0 -> gnt=001000 next cycle; late_veto 0->1 during grant -> gnt=0 next cycle.
- Data path: owner 2, data slice 2 toggles 1,0,1 -> z shows 1,0,1 delayed one cycle; on release z holds last value.
- RR (PRIO_SEL_ARBITER_RR_EN): req=6'b111111, lock=0 -> grants 0,1,2,3,4,5,0 on successive cycles.
